// File: rtl/fetch_seq.sv
// -----------------------------------------------------------------------------
// fetch_seq : instruction-fetch sequencer for the angstrom CPU.
//
// Fetches one instruction per step over a req/ack handshake, holds it in an
// instruction register for execute, turns taken branches into one-cycle PC
// load pulses, and supports halt/resume, a sticky memory-timeout fault and a
// wrapping retired-instruction counter.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   pcAddr              current PC value
//   pcInc               PC increment pulse (combinational, FETCH with ack)
//   jmpEn / jmpAddr     PC load pulse and value (registered)
//   imemReq / imemAddr  fetch request and address (combinational)
//   imemAck / imemData  memory accept and returned word
//   ir / irAddr         captured instruction and its address
//   irValid             ir is offered to execute
//   exDone              execute consumed ir
//   brTaken / brTarget  branch result, qualified by exDone
//   halt / resume       stop after current instruction / leave HALT
//   running             sequencer is not in IDLE or HALT
//   fault               sticky memory-timeout flag
//   retired             count of exDone events (wraps)
// -----------------------------------------------------------------------------
module fetch_seq #(
   parameter int ADDR_W  = 12,
   parameter int INSTR_W = 16,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pcAddr,
   output logic               pcInc,
   output logic               jmpEn,
   output logic [ADDR_W-1:0]  jmpAddr,
   output logic               imemReq,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic               imemAck,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  irAddr,
   output logic               irValid,
   input  logic               exDone,
   input  logic               brTaken,
   input  logic [ADDR_W-1:0]  brTarget,
   input  logic               halt,
   input  logic               resume,
   output logic               running,
   output logic               fault,
   output logic [15:0]        retired
);

   // Wait counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_JUMP  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     wait_q, wait_d;
   logic                 halt_pend_q, halt_pend_d;
   logic [ADDR_W-1:0]    jmp_addr_q, jmp_addr_d;
   logic                 jmp_en_q, jmp_en_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic [ADDR_W-1:0]    ir_addr_q, ir_addr_d;
   logic                 ir_valid_q, ir_valid_d;
   logic                 running_q, running_d;
   logic                 fault_q, fault_d;
   logic [15:0]          retired_q, retired_d;

   // Next-state logic, handshake strobes and register updates.
   always_comb begin
      state_d     = state_q;
      wait_d      = '0;
      halt_pend_d = halt_pend_q;
      jmp_addr_d  = jmp_addr_q;
      ir_d        = ir_q;
      ir_addr_d   = ir_addr_q;
      fault_d     = fault_q;
      retired_d   = retired_q;
      pcInc       = 1'b0;
      imemReq     = 1'b0;
      imemAddr    = '0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // PC is frozen while fetching, so pcAddr is a stable request address.
            imemReq  = 1'b1;
            imemAddr = pcAddr;
            if (imemAck) begin
               // An ack on the final wait cycle still wins over the timeout.
               ir_d      = imemData;
               ir_addr_d = pcAddr;
               pcInc     = 1'b1;
               state_d   = S_ISSUE;
            end else if (wait_q == WAIT_LAST) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         S_ISSUE: begin
            if (exDone) begin
               retired_d = retired_q + 16'd1;
               if (brTaken) begin
                  // Halt requested together with a branch is deferred past the jump.
                  jmp_addr_d  = brTarget;
                  halt_pend_d = halt;
                  state_d     = S_JUMP;
               end else if (halt) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_JUMP: begin
            // The pending halt is only consumed here, so clear it on the way out.
            halt_pend_d = 1'b0;
            if (halt_pend_q) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            if (resume && !fault_q) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_HALT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered status outputs describe the state being entered.
      ir_valid_d = (state_d == S_ISSUE);
      jmp_en_d   = (state_d == S_JUMP);
      running_d  = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_JUMP);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         halt_pend_q <= 1'b0;
         jmp_addr_q  <= '0;
         jmp_en_q    <= 1'b0;
         ir_q        <= '0;
         ir_addr_q   <= '0;
         ir_valid_q  <= 1'b0;
         running_q   <= 1'b0;
         fault_q     <= 1'b0;
         retired_q   <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         halt_pend_q <= halt_pend_d;
         jmp_addr_q  <= jmp_addr_d;
         jmp_en_q    <= jmp_en_d;
         ir_q        <= ir_d;
         ir_addr_q   <= ir_addr_d;
         ir_valid_q  <= ir_valid_d;
         running_q   <= running_d;
         fault_q     <= fault_d;
         retired_q   <= retired_d;
      end
   end

   assign jmpEn   = jmp_en_q;
   assign jmpAddr = jmp_addr_q;
   assign ir      = ir_q;
   assign irAddr  = ir_addr_q;
   assign irValid = ir_valid_q;
   assign running = running_q;
   assign fault   = fault_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_fetch_seq.sv
// -----------------------------------------------------------------------------
// tb_fetch_seq : self-checking bench for fetch_seq.
// Drives inputs on the falling edge and samples just after it. A small PC
// register and a hashed instruction memory live here; the randomized test
// predicts bus activity from the sequencing rules with an event-level model.
// -----------------------------------------------------------------------------
module tb_fetch_seq;

   logic        clk;
   logic        rst;
   logic [11:0] pcAddr;
   logic        pcInc;
   logic        jmpEn;
   logic [11:0] jmpAddr;
   logic        imemReq;
   logic [11:0] imemAddr;
   logic        imemAck;
   logic [15:0] imemData;
   logic [15:0] ir;
   logic [11:0] irAddr;
   logic        irValid;
   logic        exDone;
   logic        brTaken;
   logic [11:0] brTarget;
   logic        halt;
   logic        resume;
   logic        running;
   logic        fault;
   logic [15:0] retired;

   int n_tests;
   int n_fail;

   fetch_seq #(.ADDR_W(12), .INSTR_W(16), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .pcAddr(pcAddr), .pcInc(pcInc), .jmpEn(jmpEn),
      .jmpAddr(jmpAddr), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemAck(imemAck), .imemData(imemData), .ir(ir), .irAddr(irAddr),
      .irValid(irValid), .exDone(exDone), .brTaken(brTaken),
      .brTarget(brTarget), .halt(halt), .resume(resume), .running(running),
      .fault(fault), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program counter driven by the sequencer's strobes.
   logic [11:0] pc_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= 12'd0;
      else if (pcInc) pc_q <= pc_q + 12'd1;
      else if (jmpEn) pc_q <= jmpAddr;
   end
   assign pcAddr = pc_q;

   function automatic logic [15:0] mem_word(input logic [11:0] a);
      return {a[3:0], a} ^ 16'h5A3C;
   endfunction

   task automatic clear_inputs();
      imemAck = 1'b0; imemData = 16'd0; exDone = 1'b0; brTaken = 1'b0;
      brTarget = 12'd0; halt = 1'b0; resume = 1'b0;
   endtask

   // Reset, release on a falling edge, return just after the IDLE->FETCH edge.
   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk); imemAck = 1'b1; imemData = 16'h1234;
      @(negedge clk); imemAck = 1'b0; exDone = 1'b1; brTaken = 1'b1; brTarget = 12'h0AB;
      #1;
      n_tests++; if (ir !== 16'h1234) begin n_fail++; $display("FAIL reset_pre_ir: got %h want 1234", ir); end
      @(negedge clk); clear_inputs();
      #1;
      n_tests++; if (jmpAddr !== 12'h0AB) begin n_fail++; $display("FAIL reset_pre_jmp: got %h want 0ab", jmpAddr); end
      rst = 1'b0;
      #1;
      n_tests++;
      if ({pcInc, jmpEn, imemReq, irValid, running, fault} !== 6'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000000", {pcInc, jmpEn, imemReq, irValid, running, fault});
      end
      n_tests++;
      if ({jmpAddr, imemAddr, ir, irAddr, retired} !== 68'd0) begin
         n_fail++; $display("FAIL reset_values: got jmp=%h imem=%h ir=%h irAddr=%h ret=%h want all 0", jmpAddr, imemAddr, ir, irAddr, retired);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      imemAck = 1'b1; exDone = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); imemData = mem_word(imemAddr);
         #1;
         n_tests++; if (pcInc !== (k % 2 == 0)) begin n_fail++; $display("FAIL seq_pcinc k=%0d: got %b want %b", k, pcInc, (k % 2 == 0)); end
         if (k % 2 == 0) begin
            n_tests++; if (imemAddr !== 12'(k / 2)) begin n_fail++; $display("FAIL seq_addr k=%0d: got %h want %h", k, imemAddr, 12'(k / 2)); end
         end else begin
            n_tests++; if (ir !== mem_word(12'(k / 2))) begin n_fail++; $display("FAIL seq_ir k=%0d: got %h want %h", k, ir, mem_word(12'(k / 2))); end
         end
      end
      @(negedge clk); #1;
      n_tests++; if (retired !== 16'd5) begin n_fail++; $display("FAIL seq_retired: got %0d want 5", retired); end
      clear_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      imemAck = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         imemData = mem_word(imemAddr);
         exDone   = 1'b1;
         brTaken  = (k == 6) || (k == 7);
         brTarget = (k == 7) ? 12'h0F0 : 12'h555;
         #1;
         if (k == 6) begin
            n_tests++; if (imemAddr !== 12'h003) begin n_fail++; $display("FAIL br_fetch3: got %h want 003", imemAddr); end
         end
         if (k == 8) begin
            n_tests++; if ({jmpEn, pcInc} !== 2'b10) begin n_fail++; $display("FAIL br_pulse: got jmpEn/pcInc=%b want 10", {jmpEn, pcInc}); end
            n_tests++; if (jmpAddr !== 12'h0F0) begin n_fail++; $display("FAIL br_addr: got %h want 0f0", jmpAddr); end
         end
         if (k == 9) begin
            n_tests++; if ({jmpEn, imemReq} !== 2'b01) begin n_fail++; $display("FAIL br_after: got jmpEn/req=%b want 01", {jmpEn, imemReq}); end
            n_tests++; if (imemAddr !== 12'h0F0) begin n_fail++; $display("FAIL br_target_fetch: got %h want 0f0", imemAddr); end
         end
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         imemAck  = (k == 4);
         imemData = (k == 4) ? 16'hBEEF : 16'h0BAD + 16'(k);
         #1;
         n_tests++; if ({imemReq, imemAddr} !== {1'b1, 12'h000}) begin n_fail++; $display("FAIL wait_req k=%0d: got req=%b addr=%h want 1/000", k, imemReq, imemAddr); end
         n_tests++; if (pcInc !== (k == 4)) begin n_fail++; $display("FAIL wait_pcinc k=%0d: got %b want %b", k, pcInc, (k == 4)); end
      end
      @(negedge clk); imemAck = 1'b0; #1;
      n_tests++; if ({ir, irAddr} !== {16'hBEEF, 12'h000}) begin n_fail++; $display("FAIL wait_capture: got ir=%h irAddr=%h want beef/000", ir, irAddr); end
      n_tests++; if ({irValid, fault} !== 2'b10) begin n_fail++; $display("FAIL wait_status: got valid/fault=%b want 10", {irValid, fault}); end
   endtask

   task automatic test_timeout();
      do_reset();
      for (int k = 0; k < 15; k++) begin
         @(negedge clk); #1;
         n_tests++; if ({imemReq, running, fault} !== 3'b110) begin n_fail++; $display("FAIL to_wait k=%0d: got req/run/fault=%b want 110", k, {imemReq, running, fault}); end
      end
      @(negedge clk); #1;
      n_tests++; if ({imemReq, running, fault} !== 3'b001) begin n_fail++; $display("FAIL to_fault: got req/run/fault=%b want 001", {imemReq, running, fault}); end
      resume = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_tests++; if ({imemReq, running, fault} !== 3'b001) begin n_fail++; $display("FAIL to_resume_ignored: got req/run/fault=%b want 001", {imemReq, running, fault}); end
      resume = 1'b0;
      rst = 1'b0; #1;
      n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL to_rst_clears: got %b want 0", fault); end
   endtask

   task automatic test_timeout_edge();
      do_reset();
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         imemAck = (k == 14); imemData = 16'h7E57;
      end
      @(negedge clk); imemAck = 1'b0; #1;
      n_tests++; if ({fault, irValid, ir} !== {1'b0, 1'b1, 16'h7E57}) begin n_fail++; $display("FAIL to_edge_ack: got fault=%b valid=%b ir=%h want 0/1/7e57", fault, irValid, ir); end
   endtask

   task automatic test_halt_branch();
      do_reset();
      @(negedge clk); imemAck = 1'b1; imemData = mem_word(imemAddr);
      @(negedge clk); imemAck = 1'b0; exDone = 1'b1; halt = 1'b1; brTaken = 1'b1; brTarget = 12'h020;
      @(negedge clk); clear_inputs(); #1;
      n_tests++; if ({jmpEn, pcInc, running} !== 3'b101) begin n_fail++; $display("FAIL hb_jump: got jmpEn/pcInc/run=%b want 101", {jmpEn, pcInc, running}); end
      n_tests++; if (jmpAddr !== 12'h020) begin n_fail++; $display("FAIL hb_addr: got %h want 020", jmpAddr); end
      @(negedge clk); exDone = 1'b1; brTaken = 1'b1; #1;
      n_tests++; if ({jmpEn, imemReq, running} !== 3'b000) begin n_fail++; $display("FAIL hb_halted: got jmpEn/req/run=%b want 000", {jmpEn, imemReq, running}); end
      @(negedge clk); #1;
      n_tests++; if ({imemReq, running} !== 2'b00) begin n_fail++; $display("FAIL hb_stays: got req/run=%b want 00", {imemReq, running}); end
      clear_inputs(); resume = 1'b1;
      @(negedge clk); resume = 1'b0; #1;
      n_tests++; if ({imemReq, imemAddr} !== {1'b1, 12'h020}) begin n_fail++; $display("FAIL hb_resume: got req=%b addr=%h want 1/020", imemReq, imemAddr); end
   endtask

   task automatic test_wrap();
      do_reset();
      @(negedge clk); imemAck = 1'b1; imemData = mem_word(imemAddr);
      @(negedge clk); imemAck = 1'b0; exDone = 1'b1; halt = 1'b1;
      @(negedge clk); clear_inputs(); #1;
      n_tests++; if ({retired, running} !== {16'd1, 1'b0}) begin n_fail++; $display("FAIL wrap_pre: got ret=%h run=%b want 0001/0", retired, running); end
      force dut.retired_q = 16'hFFFF;
      @(negedge clk);
      release dut.retired_q;
      resume = 1'b1;
      @(negedge clk); resume = 1'b0; imemAck = 1'b1; imemData = mem_word(imemAddr); #1;
      n_tests++; if (retired !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", retired); end
      @(negedge clk); imemAck = 1'b0; exDone = 1'b1;
      @(negedge clk); exDone = 1'b0; #1;
      n_tests++; if (retired !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h want 0000", retired); end
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk); #1;
      n_tests++; if (imemReq !== 1'b1) begin n_fail++; $display("FAIL ar_req_before: got %b want 1", imemReq); end
      #2 rst = 1'b0; #1;
      n_tests++; if ({imemReq, running, irValid} !== 3'b000) begin n_fail++; $display("FAIL ar_fetch: got req/run/valid=%b want 000", {imemReq, running, irValid}); end
      do_reset();
      @(negedge clk); imemAck = 1'b1; imemData = 16'hC0DE;
      @(negedge clk); imemAck = 1'b0; #1;
      n_tests++; if (irValid !== 1'b1) begin n_fail++; $display("FAIL ar_valid_before: got %b want 1", irValid); end
      #2 rst = 1'b0; #1;
      n_tests++; if ({irValid, ir} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL ar_issue: got valid=%b ir=%h want 0/0000", irValid, ir); end
   endtask

   // Randomized run against an event-level prediction of the bus activity.
   task automatic test_random(input int n_instr);
      logic [11:0] m_addr, m_iraddr, e_tgt;
      logic [15:0] m_ret, m_ir;
      logic        e_req, e_valid, e_jmp, e_quiet, pend_halt, acked;
      logic        n_req, n_valid, n_jmp, n_quiet;
      int          ack_wait, ex_wait, quiet_wait, done, guard;
      do_reset();
      m_addr = 12'd0; m_iraddr = 12'd0; e_tgt = 12'd0; m_ret = 16'd0; m_ir = 16'd0;
      e_req = 1'b1; e_valid = 1'b0; e_jmp = 1'b0; e_quiet = 1'b0; pend_halt = 1'b0;
      ack_wait = $urandom_range(0, 3); ex_wait = $urandom_range(0, 2); quiet_wait = $urandom_range(0, 3);
      done = 0; guard = 0;
      while (done < n_instr && guard < 20000) begin
         @(negedge clk);
         guard++;
         imemAck = 1'b0; exDone = 1'b0;
         imemData = 16'($urandom); brTaken = 1'($urandom); halt = 1'($urandom);
         brTarget = 12'($urandom); resume = 1'($urandom) & ~e_quiet;
         acked = 1'b0;
         #1;
         n_tests++; if ({imemReq, irValid, jmpEn, running} !== {e_req, e_valid, e_jmp, ~e_quiet}) begin
            n_fail++; $display("FAIL rnd_status cyc=%0d: got req/valid/jmp/run=%b want %b", guard, {imemReq, irValid, jmpEn, running}, {e_req, e_valid, e_jmp, ~e_quiet});
         end
         n_tests++; if (retired !== m_ret) begin n_fail++; $display("FAIL rnd_retired cyc=%0d: got %h want %h", guard, retired, m_ret); end
         n_req = 1'b0; n_valid = 1'b0; n_jmp = 1'b0; n_quiet = 1'b0;
         if (e_req) begin
            n_tests++; if (imemAddr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d: got %h want %h", guard, imemAddr, m_addr); end
            if (ack_wait == 0) begin
               imemAck = 1'b1; imemData = mem_word(m_addr); acked = 1'b1;
               m_ir = mem_word(m_addr); m_iraddr = m_addr; m_addr = m_addr + 12'd1;
               n_valid = 1'b1;
               ack_wait = ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
            end else begin
               ack_wait--; n_req = 1'b1;
            end
         end else if (e_valid) begin
            n_tests++; if ({ir, irAddr} !== {m_ir, m_iraddr}) begin n_fail++; $display("FAIL rnd_ir cyc=%0d: got %h@%h want %h@%h", guard, ir, irAddr, m_ir, m_iraddr); end
            if (ex_wait == 0) begin
               exDone = 1'b1;
               brTaken = ($urandom_range(0, 3) == 0);
               halt = ($urandom_range(0, 7) == 0);
               m_ret = m_ret + 16'd1; done++;
               if (brTaken) begin
                  e_tgt = brTarget; m_addr = brTarget; pend_halt = halt; n_jmp = 1'b1;
               end else if (halt) begin
                  n_quiet = 1'b1;
               end else begin
                  n_req = 1'b1;
               end
               ex_wait = $urandom_range(0, 2);
            end else begin
               ex_wait--; n_valid = 1'b1;
            end
         end else if (e_jmp) begin
            n_tests++; if (jmpAddr !== e_tgt) begin n_fail++; $display("FAIL rnd_jmpaddr cyc=%0d: got %h want %h", guard, jmpAddr, e_tgt); end
            n_quiet = pend_halt; n_req = ~pend_halt; pend_halt = 1'b0;
         end else begin
            if (quiet_wait == 0) begin
               resume = 1'b1; n_req = 1'b1; quiet_wait = $urandom_range(0, 3);
            end else begin
               quiet_wait--; n_quiet = 1'b1;
            end
         end
         #1;
         n_tests++; if ({pcInc, jmpEn} !== {acked, e_jmp}) begin n_fail++; $display("FAIL rnd_strobes cyc=%0d: got pcInc/jmpEn=%b want %b", guard, {pcInc, jmpEn}, {acked, e_jmp}); end
         e_req = n_req; e_valid = n_valid; e_jmp = n_jmp; e_quiet = n_quiet;
      end
      n_tests++; if (done < n_instr) begin n_fail++; $display("FAIL rnd_budget: retired %0d of %0d instructions", done, n_instr); end
      clear_inputs();
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_timeout_edge();
      test_halt_branch();
      test_wrap();
      test_async_reset();
      test_random(300);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
